// File: rtl/hmnoc_layer_sequencer.sv
// Layer sequencer for the 4-cluster HMNOC array (west_0, west_1, east_0, east_1).
// Runs one conv layer: weight broadcast, iact load, then per output row a compute
// start followed by a drain of X_DIM psums from every cluster GLB.
module hmnoc_layer_sequencer #(
    parameter int unsigned DATA_BITWIDTH  = 16,
    parameter int unsigned ADDR_BITWIDTH  = 8,
    parameter int unsigned KERNEL_SIZE    = 3,
    parameter int unsigned ACT_SIZE       = 7,
    parameter int unsigned X_DIM          = 5,
    parameter int unsigned PSUM_LOAD_ADDR = 0,
    parameter int unsigned FILL_CYC       = 3,
    parameter int unsigned START_LEN      = 2,
    parameter int unsigned SETTLE_CYC     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       layer_start,
    output logic                       busy,
    output logic                       layer_done,
    output logic                       wght_en,
    output logic [3:0]                 iact_en,
    output logic [15:0]                mode_wght,
    output logic [15:0]                mode_iact,
    output logic [15:0]                mode_psum,
    output logic                       noc_start,
    input  logic                       load_done,
    input  logic                       compute_done,
    output logic [3:0]                 psum_r_req,
    output logic [ADDR_BITWIDTH-1:0]   psum_r_addr,
    input  logic [4*DATA_BITWIDTH-1:0] psum_r_data,
    output logic                       psum_out_valid,
    input  logic                       psum_out_ready,
    output logic [4*DATA_BITWIDTH-1:0] psum_out_data,
    output logic [7:0]                 psum_out_row,
    output logic [7:0]                 psum_out_col
);

    localparam int unsigned WLOAD_LEN = KERNEL_SIZE * KERNEL_SIZE + FILL_CYC;
    localparam int unsigned ILOAD_LEN = ACT_SIZE * ACT_SIZE + FILL_CYC;
    localparam int unsigned NUM_ROWS  = ACT_SIZE - KERNEL_SIZE + 1;

    localparam logic [3:0] MODE_ALL       = 4'd0;
    localparam logic [3:0] MODE_WEST      = 4'd3;
    localparam logic [3:0] MODE_EAST      = 4'd4;
    localparam logic [3:0] MODE_EASTSOUTH = 4'd6;
    localparam logic [3:0] MODE_CLOSED    = 4'd11;

    localparam logic [15:0] MODES_CLOSED = {4{MODE_CLOSED}};
    // Weight broadcast from west_0, nibbles low to high: ALL, EASTSOUTH, WEST, EAST
    localparam logic [15:0] MODES_WGHT   = {MODE_EAST, MODE_WEST, MODE_EASTSOUTH, MODE_ALL};
    localparam logic [15:0] MODES_IACT   = {4{MODE_WEST}};

    typedef enum logic [3:0] {
        StIdle, StWload, StWwait, StIload, StIwait, StStart,
        StComp, StSettle, StRd, StCap, StHold, StDone
    } state_t;

    state_t                     state_q, state_d;
    logic [15:0]                cnt_q, cnt_d;
    logic                       seen_low_q, seen_low_d;
    logic [7:0]                 row_q, row_d;
    logic [7:0]                 col_q, col_d;
    logic [ADDR_BITWIDTH-1:0]   addr_q, addr_d;
    logic [4*DATA_BITWIDTH-1:0] data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       wait_level;

    // State and datapath registers; synchronous reset aborts any layer in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            seen_low_q <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seen_low_q <= seen_low_d;
            row_q      <= row_d;
            col_q      <= col_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
        end
    end

    // Next-state, datapath updates and Moore decode of the router/GLB controls
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        seen_low_d = seen_low_q;
        row_d      = row_q;
        col_d      = col_q;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        busy       = (state_q != StIdle);
        layer_done = 1'b0;
        wght_en    = 1'b0;
        iact_en    = 4'h0;
        mode_wght  = MODES_CLOSED;
        mode_iact  = MODES_CLOSED;
        mode_psum  = MODES_CLOSED;
        noc_start  = 1'b0;
        psum_r_req = 4'h0;
        wait_level = (state_q == StComp) ? compute_done : load_done;

        case (state_q)
            StIdle: begin
                if (layer_start) state_d = StWload;
            end
            StWload: begin
                wght_en   = 1'b1;
                mode_wght = MODES_WGHT;
                if (cnt_q == 16'(WLOAD_LEN - 1)) state_d = StWwait;
            end
            StWwait: begin
                if (seen_low_q && load_done) state_d = StIload;
            end
            StIload: begin
                iact_en   = 4'hF;
                mode_iact = MODES_IACT;
                if (cnt_q == 16'(ILOAD_LEN - 1)) state_d = StIwait;
            end
            StIwait: begin
                if (seen_low_q && load_done) state_d = StStart;
            end
            StStart: begin
                noc_start = 1'b1;
                if (cnt_q == 16'(START_LEN - 1)) state_d = StComp;
            end
            StComp: begin
                if (seen_low_q && compute_done) state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == 16'(SETTLE_CYC - 1)) state_d = StRd;
            end
            StRd: begin
                psum_r_req = 4'hF;
                state_d    = StCap;
            end
            StCap: begin
                // Read data arrives one cycle after the request
                data_d  = psum_r_data;
                valid_d = 1'b1;
                state_d = StHold;
            end
            StHold: begin
                if (psum_out_ready) begin
                    valid_d = 1'b0;
                    if (col_q != 8'(X_DIM - 1)) begin
                        col_d   = col_q + 8'd1;
                        state_d = StRd;
                    end else if (row_q != 8'(NUM_ROWS - 1)) begin
                        row_d   = row_q + 8'd1;
                        col_d   = '0;
                        state_d = StStart;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                layer_done = 1'b1;
                row_d      = '0;
                col_d      = '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Edge detect: only a low seen inside the current state arms acceptance
        if (state_d != state_q) begin
            cnt_d      = '0;
            seen_low_d = 1'b0;
        end else if (!wait_level) begin
            seen_low_d = 1'b1;
        end

        // Address wraps modulo the GLB address space
        if (state_d == StRd && state_q != StRd) begin
            addr_d = ADDR_BITWIDTH'(PSUM_LOAD_ADDR + 32'(row_d) * X_DIM + 32'(col_d));
        end
    end

    assign psum_r_addr    = addr_q;
    assign psum_out_valid = valid_q;
    assign psum_out_data  = data_q;
    assign psum_out_row   = row_q;
    assign psum_out_col   = col_q;

endmodule

// File: tb/tb_hmnoc_layer_sequencer.sv
// Directed bench for hmnoc_layer_sequencer: responds to load/compute handshakes,
// models the psum GLB read port and checks every phase of a layer.
module tb_hmnoc_layer_sequencer;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int XD = 5;
    localparam int NR = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          layer_start = 1'b0;
    logic          load_done = 1'b0;
    logic          compute_done = 1'b0;
    logic          psum_out_ready = 1'b1;
    logic [4*DW-1:0] psum_r_data = '0;
    logic          busy, layer_done, wght_en, noc_start, psum_out_valid;
    logic [3:0]    iact_en, psum_r_req;
    logic [15:0]   mode_wght, mode_iact, mode_psum;
    logic [AW-1:0] psum_r_addr;
    logic [4*DW-1:0] psum_out_data;
    logic [7:0]    psum_out_row, psum_out_col;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_out = 0;

    hmnoc_layer_sequencer dut (
        .clk(clk), .reset(reset), .layer_start(layer_start), .busy(busy),
        .layer_done(layer_done), .wght_en(wght_en), .iact_en(iact_en),
        .mode_wght(mode_wght), .mode_iact(mode_iact), .mode_psum(mode_psum),
        .noc_start(noc_start), .load_done(load_done), .compute_done(compute_done),
        .psum_r_req(psum_r_req), .psum_r_addr(psum_r_addr), .psum_r_data(psum_r_data),
        .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready),
        .psum_out_data(psum_out_data), .psum_out_row(psum_out_row),
        .psum_out_col(psum_out_col)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4*DW-1:0] glb_word(input logic [AW-1:0] a);
        logic [4*DW-1:0] d;
        for (int l = 0; l < 4; l++) d[l*DW +: DW] = {4'(l + 1), 4'h5, a};
        return d;
    endfunction

    // GLB read port with one cycle of latency
    always @(posedge clk) begin
        if (psum_r_req == 4'hF) psum_r_data <= glb_word(psum_r_addr);
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic start_layer();
        layer_start = 1'b1;
        step();
        layer_start = 1'b0;
    endtask

    task automatic pulse_load_done();
        step();
        step();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
    endtask

    task automatic check_wload(input bit raise_ld);
        int n = 0;
        while (wght_en === 1'b1 && n < 40) begin
            checks++;
            if (mode_wght !== 16'h4360) begin
                errors++;
                $display("FAIL wload_mode: got %h want 4360", mode_wght);
            end
            n++;
            if (raise_ld && n == 5) load_done = 1'b1;
            step();
        end
        checks++;
        if (n !== 12) begin
            errors++;
            $display("FAIL wload_len: got %0d cycles want 12", n);
        end
        checks++;
        if (mode_wght !== 16'hBBBB) begin
            errors++;
            $display("FAIL wload_closed: got %h want BBBB", mode_wght);
        end
    endtask

    task automatic check_iload();
        int n = 0;
        while (iact_en === 4'hF && n < 80) begin
            checks++;
            if (mode_iact !== 16'h3333) begin
                errors++;
                $display("FAIL iload_mode: got %h want 3333", mode_iact);
            end
            n++;
            step();
        end
        checks++;
        if (n !== 52) begin
            errors++;
            $display("FAIL iload_len: got %0d cycles want 52", n);
        end
        checks++;
        if ({iact_en, mode_iact, mode_psum} !== {4'h0, 16'hBBBB, 16'hBBBB}) begin
            errors++;
            $display("FAIL iload_closed: got en=%h mi=%h mp=%h want 0 BBBB BBBB",
                     iact_en, mode_iact, mode_psum);
        end
    endtask

    task automatic run_row(input int r, input int stall_col);
        int n;
        int rise;
        int prev_rd;
        logic [4*DW-1:0] held;
        n = 0;
        while (noc_start !== 1'b1 && n < 20) begin step(); n++; end
        checks++;
        if (n >= 20) begin errors++; $display("FAIL start_timeout: row %0d", r); end
        n = 0;
        while (noc_start === 1'b1 && n < 10) begin step(); n++; end
        checks++;
        if (n !== 2) begin errors++; $display("FAIL start_len: got %0d want 2", n); end
        step();
        step();
        compute_done = 1'b1;
        rise = cyc + 1;
        step();
        compute_done = 1'b0;
        prev_rd = 0;
        for (int c = 0; c < XD; c++) begin
            n = 0;
            while (psum_r_req !== 4'hF && n < 30) begin step(); n++; end
            checks++;
            if (n >= 30) begin errors++; $display("FAIL req_timeout: row %0d col %0d", r, c); end
            if (c == 0) begin
                checks++;
                if (cyc - rise !== 8) begin
                    errors++;
                    $display("FAIL settle: got %0d cycles want 8", cyc - rise);
                end
            end else if (c - 1 != stall_col) begin
                checks++;
                if (cyc - prev_rd !== 3) begin
                    errors++;
                    $display("FAIL req_spacing: got %0d cycles want 3", cyc - prev_rd);
                end
            end
            prev_rd = cyc;
            checks++;
            if (psum_r_addr !== 8'(r * XD + c)) begin
                errors++;
                $display("FAIL rd_addr: got %0d want %0d", psum_r_addr, r * XD + c);
            end
            if (c == stall_col) psum_out_ready = 1'b0;
            step();
            checks++;
            if ({psum_out_valid, psum_r_req} !== 5'b0) begin
                errors++;
                $display("FAIL cap: got valid=%b req=%h want 0 0", psum_out_valid, psum_r_req);
            end
            step();
            checks++;
            if ({psum_out_valid, psum_out_row, psum_out_col, psum_out_data} !==
                {1'b1, 8'(r), 8'(c), glb_word(8'(r * XD + c))}) begin
                errors++;
                $display("FAIL hold_out: got v=%b r=%0d c=%0d d=%h want 1 %0d %0d %h",
                         psum_out_valid, psum_out_row, psum_out_col, psum_out_data,
                         r, c, glb_word(8'(r * XD + c)));
            end
            if (psum_out_valid === 1'b1) n_out++;
            if (c == stall_col) begin
                held = glb_word(8'(r * XD + c));
                for (int i = 0; i < 5; i++) begin
                    step();
                    checks++;
                    if ({psum_out_valid, psum_out_row, psum_out_col, psum_out_data, psum_r_req}
                        !== {1'b1, 8'(r), 8'(c), held, 4'h0}) begin
                        errors++;
                        $display("FAIL stall_stable: got v=%b r=%0d c=%0d req=%h",
                                 psum_out_valid, psum_out_row, psum_out_col, psum_r_req);
                    end
                end
                psum_out_ready = 1'b1;
            end
            step();
            checks++;
            if (psum_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL accept: valid got %b want 0", psum_out_valid);
            end
        end
    endtask

    task automatic check_done();
        checks++;
        if ({layer_done, busy} !== 2'b11) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b want 1 1", layer_done, busy);
        end
        step();
        checks++;
        if ({layer_done, busy, psum_out_row, psum_out_col} !== 18'b0) begin
            errors++;
            $display("FAIL done_after: got done=%b busy=%b r=%0d c=%0d want 0",
                     layer_done, busy, psum_out_row, psum_out_col);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({busy, layer_done, wght_en, iact_en, noc_start, psum_r_req, psum_out_valid,
             mode_wght, mode_iact, mode_psum} !== {13'b0, 48'hBBBB_BBBB_BBBB}) begin
            errors++;
            $display("FAIL %s: got busy=%b en=%b/%h start=%b req=%h v=%b modes=%h %h %h",
                     name, busy, wght_en, iact_en, noc_start, psum_r_req, psum_out_valid,
                     mode_wght, mode_iact, mode_psum);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        check_idle_outputs("reset_ctrl");
        checks++;
        if ({psum_r_addr, psum_out_data, psum_out_row, psum_out_col} !== '0) begin
            errors++;
            $display("FAIL reset_data: got a=%h d=%h r=%h c=%h want 0",
                     psum_r_addr, psum_out_data, psum_out_row, psum_out_col);
        end
        reset = 1'b0;
        step();
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_weight_phase();
        start_layer();
        check_wload(1'b1);
    endtask

    task automatic test_wwait_edge();
        for (int i = 0; i < 10; i++) begin
            layer_start = (i == 3);
            checks++;
            if ({busy, wght_en, iact_en} !== 6'b100000) begin
                errors++;
                $display("FAIL wwait_hold: got busy=%b wen=%b ien=%h want 1 0 0",
                         busy, wght_en, iact_en);
            end
            step();
        end
        layer_start = 1'b0;
        load_done = 1'b0;
        pulse_load_done();
        checks++;
        if (iact_en !== 4'hF) begin
            errors++;
            $display("FAIL wwait_edge: iact_en got %h want F", iact_en);
        end
    endtask

    task automatic test_iact_phase();
        check_iload();
        pulse_load_done();
    endtask

    task automatic test_rows();
        n_out = 0;
        for (int r = 0; r < NR; r++) run_row(r, (r == 3) ? 3 : -1);
        checks++;
        if (n_out !== 25) begin errors++; $display("FAIL row_outputs: got %0d want 25", n_out); end
        check_done();
    endtask

    task automatic test_reset_mid_comp();
        int n = 0;
        start_layer();
        check_wload(1'b0);
        pulse_load_done();
        check_iload();
        pulse_load_done();
        while (noc_start === 1'b1 && n < 10) begin step(); n++; end
        step();
        reset = 1'b1;
        step();
        check_idle_outputs("reset_in_comp");
        reset = 1'b0;
        compute_done = 1'b1;
        step();
        compute_done = 1'b0;
        step();
        check_idle_outputs("idle_after_abort");
    endtask

    task automatic test_full_layer();
        n_out = 0;
        start_layer();
        check_wload(1'b0);
        pulse_load_done();
        check_iload();
        pulse_load_done();
        for (int r = 0; r < NR; r++) run_row(r, -1);
        checks++;
        if (n_out !== 25) begin errors++; $display("FAIL layer_outputs: got %0d want 25", n_out); end
        check_done();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_weight_phase();
        test_wwait_edge();
        test_iact_phase();
        test_rows();
        test_reset_mid_comp();
        test_full_layer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
